// File: rtl/eka_mem_pkg.sv
// Shared definitions for the Eka memory responder.
//   mem_state_t      : responder FSM state (IDLE, LOAD, RUN, HALT)
//   CYCLE_ADDR       : MMIO word returning the RUN cycle counter
//   TOHOST_ADDR      : MMIO word whose store halts the core
//   NOP_WORD_DEFAULT : instruction returned when a fetch is not served
package eka_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } mem_state_t;

  localparam logic [31:0] CYCLE_ADDR       = 32'hFFFF_FFF0;
  localparam logic [31:0] TOHOST_ADDR      = 32'hFFFF_FFF4;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/eka_mem_array.sv
// Unified instruction/data word array.
//   clk        : write clock
//   fetch_idx  : instruction word index, fetch_data is its word (asynchronous)
//   data_idx   : data word index, data_rd is its word (asynchronous)
//   wr_en      : write enable, wr_data lands at wr_idx on the rising edge
// Contents are never reset, so a preloaded image survives a reset pulse.
module eka_mem_array
  import eka_mem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] fetch_idx,
  output logic [31:0]      fetch_data,
  input  logic [IDX_W-1:0] data_idx,
  output logic [31:0]      data_rd,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data
);

  logic [31:0] mem [MEM_WORDS];

  assign fetch_data = mem[fetch_idx];
  assign data_rd    = mem[data_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/eka_mem_responder_v1.sv
// Memory-side responder for the Eka single-cycle core.
// Preloads the program image from a word stream while holding the core in
// reset, then serves combinational fetches/loads and edge-committed stores.
// Exposes a RUN cycle counter (CYCLE_ADDR) and a tohost/halt word (TOHOST_ADDR).
//   clk, reset                 : clock, asynchronous active-low reset
//   inst_addr / instruction    : fetch byte address / fetched word (combinational)
//   data_addr, mem_rd, mem_wr  : core load/store request
//   mem_wr_data / mem_rd_data  : store data / load data (combinational)
//   load_valid/data/last/ready : preload word stream handshake
//   core_reset                 : active-high reset to the core (low only in RUN)
//   halt, tohost               : program wrote tohost, and the value written
module eka_mem_responder_v1
  import eka_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          MEM_WORDS  = 1024,
  parameter logic [31:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [31:0]           instruction,
  input  logic [31:0]           data_addr,
  input  logic [31:0]           mem_wr_data,
  input  logic                  mem_wr,
  input  logic                  mem_rd,
  output logic [31:0]           mem_rd_data,
  input  logic                  load_valid,
  input  logic [31:0]           load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  core_reset,
  output logic                  halt,
  output logic [31:0]           tohost
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  mem_state_t       state;
  logic [IDX_W-1:0] load_ptr;
  logic [31:0]      cycle_cnt;

  // Word addresses; byte-offset bits drop out here.
  logic [ADDR_WIDTH-1:0] inst_word;
  logic [31:0]           data_word;
  logic                  inst_in_range;
  logic                  data_in_range;
  logic                  is_run;
  logic                  tohost_store;
  logic                  last_accept;

  logic [31:0]      arr_fetch;
  logic [31:0]      arr_data;
  logic             arr_we;
  logic [IDX_W-1:0] arr_widx;
  logic [31:0]      arr_wdata;

  assign inst_word     = inst_addr >> 2;
  assign data_word     = data_addr >> 2;
  assign inst_in_range = (inst_word[ADDR_WIDTH-1:IDX_W] == '0);
  assign data_in_range = (data_word[31:IDX_W] == '0);
  assign is_run        = (state == RUN);
  assign tohost_store  = mem_wr && (data_addr == TOHOST_ADDR);
  // The stream ends on an explicit last flag or when the array is full.
  assign last_accept   = load_last || (&load_ptr);

  eka_mem_array #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk        (clk),
    .fetch_idx  (inst_word[IDX_W-1:0]),
    .fetch_data (arr_fetch),
    .data_idx   (data_word[IDX_W-1:0]),
    .data_rd    (arr_data),
    .wr_en      (arr_we),
    .wr_idx     (arr_widx),
    .wr_data    (arr_wdata)
  );

  // Write port owner: the preload stream in LOAD, the core in RUN.
  always_comb begin
    arr_we    = 1'b0;
    arr_widx  = load_ptr;
    arr_wdata = load_data;
    case (state)
      LOAD: arr_we = load_valid;
      RUN: begin
        arr_we    = mem_wr && data_in_range;
        arr_widx  = data_word[IDX_W-1:0];
        arr_wdata = mem_wr_data;
      end
      default: arr_we = 1'b0;
    endcase
  end

  assign instruction = (is_run && inst_in_range) ? arr_fetch : NOP_WORD;

  always_comb begin
    mem_rd_data = '0;
    if (is_run && mem_rd) begin
      if (data_addr == CYCLE_ADDR) begin
        mem_rd_data = cycle_cnt;
      end else if (data_addr == TOHOST_ADDR) begin
        mem_rd_data = tohost;
      end else if (data_in_range) begin
        mem_rd_data = arr_data;
      end
    end
  end

  // Control FSM with registered outputs, each set alongside its next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      load_ptr   <= '0;
      cycle_cnt  <= '0;
      tohost     <= '0;
      halt       <= 1'b0;
      core_reset <= 1'b1;
      load_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state      <= LOAD;
          load_ready <= 1'b1;
        end
        LOAD: begin
          if (load_valid) begin
            load_ptr <= load_ptr + 1'b1;
            if (last_accept) begin
              state      <= RUN;
              load_ready <= 1'b0;
              core_reset <= 1'b0;
            end
          end
        end
        RUN: begin
          cycle_cnt <= cycle_cnt + 32'd1;
          if (tohost_store) begin
            tohost     <= mem_wr_data;
            state      <= HALT;
            halt       <= 1'b1;
            core_reset <= 1'b1;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eka_mem_responder_v1.sv
module tb_eka_mem_responder_v1;

  localparam logic [31:0] CYC   = 32'hFFFF_FFF0;
  localparam logic [31:0] TOH   = 32'hFFFF_FFF4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          WORDS = 1024;
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_HALT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] mem_wr_data = '0;
  logic        mem_wr = 1'b0;
  logic        mem_rd = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic [31:0] instruction;
  logic [31:0] mem_rd_data;
  logic        load_ready;
  logic        core_reset;
  logic        halt;
  logic [31:0] tohost;

  eka_mem_responder_v1 dut (
    .clk         (clk),
    .reset       (reset),
    .inst_addr   (inst_addr),
    .instruction (instruction),
    .data_addr   (data_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr      (mem_wr),
    .mem_rd      (mem_rd),
    .mem_rd_data (mem_rd_data),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .core_reset  (core_reset),
    .halt        (halt),
    .tohost      (tohost)
  );

  always #5 clk = ~clk;

  // Scoreboard entries: which output, and what it must show this cycle.
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: array image, stream pointer, phase, MMIO words.
  logic [31:0] m_mem   [WORDS];
  bit          m_known [WORDS];
  int          m_phase = P_IDLE;
  int          m_ptr = 0;
  logic [31:0] m_cycles = '0;
  logic [31:0] m_tohost = '0;

  function automatic void expect_out(string n, int s, logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel  = s;
    e.val  = v;
    sb.push_back(e);
  endfunction

  function automatic void model_reset();
    m_phase  = P_IDLE;
    m_ptr    = 0;
    m_cycles = '0;
    m_tohost = '0;
  endfunction

  function automatic void push_expect();
    int idx;
    if (m_phase == P_RUN && inst_addr < 32'h1000) begin
      idx = int'(inst_addr >> 2);
      if (m_known[idx]) expect_out("instruction", 0, m_mem[idx]);
    end else begin
      expect_out("instruction", 0, NOP);
    end
    if (m_phase == P_RUN && mem_rd) begin
      if (data_addr == CYC) expect_out("rd_cycle", 1, m_cycles);
      else if (data_addr == TOH) expect_out("rd_tohost", 1, m_tohost);
      else if (data_addr < 32'h1000) begin
        idx = int'(data_addr >> 2);
        if (m_known[idx]) expect_out("rd_array", 1, m_mem[idx]);
      end else expect_out("rd_oob", 1, 32'd0);
    end else begin
      expect_out("rd_idle", 1, 32'd0);
    end
    expect_out("core_reset", 2, {31'd0, m_phase != P_RUN});
    expect_out("load_ready", 3, {31'd0, m_phase == P_LOAD});
    expect_out("halt", 4, {31'd0, m_phase == P_HALT});
    expect_out("tohost", 5, m_tohost);
  endfunction

  function automatic void commit();
    if (!reset) return;
    case (m_phase)
      P_IDLE: m_phase = P_LOAD;
      P_LOAD: if (load_valid) begin
        m_mem[m_ptr]   = load_data;
        m_known[m_ptr] = 1'b1;
        if (load_last || m_ptr == WORDS - 1) m_phase = P_RUN;
        m_ptr = (m_ptr + 1) % WORDS;
      end
      P_RUN: begin
        m_cycles = m_cycles + 32'd1;
        if (mem_wr) begin
          if (data_addr == TOH) begin
            m_tohost = mem_wr_data;
            m_phase  = P_HALT;
          end else if (data_addr < 32'h1000) begin
            m_mem[int'(data_addr >> 2)]   = mem_wr_data;
            m_known[int'(data_addr >> 2)] = 1'b1;
          end
        end
      end
      default: ;
    endcase
  endfunction

  // Monitor: outputs are combinational/registered, compared mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       act = instruction;
        1:       act = mem_rd_data;
        2:       act = {31'd0, core_reset};
        3:       act = {31'd0, load_ready};
        4:       act = {31'd0, halt};
        default: act = tohost;
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s at %0t: got %h expected %h", e.name, $time, act, e.val);
      end
    end
  end

  task automatic cycle();
    push_expect();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic set_idle();
    inst_addr   = '0;
    data_addr   = '0;
    mem_wr_data = '0;
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    load_valid  = 1'b0;
    load_last   = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr(int span);
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'h1000 + ($urandom & 32'h000F_FFFF);
    if (r == 1) return CYC;
    return 32'(($urandom_range(0, span - 1) << 2) | ($urandom & 3));
  endfunction

  task automatic apply_reset();
    set_idle();
    reset = 1'b0;
    model_reset();
    repeat (2) cycle();
    reset = 1'b1;
  endtask

  // Streams n words; core-side inputs are scrambled to show they are ignored.
  task automatic load_words(int n, bit use_last, bit dense);
    int acc = 0;
    int guard = 0;
    bit hs;
    while (acc < n && guard < 8 * n + 16) begin
      load_valid  = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
      load_data   = $urandom;
      load_last   = use_last && (acc == n - 1);
      inst_addr   = rand_addr(64);
      data_addr   = rand_addr(64);
      mem_rd      = $urandom_range(0, 1);
      mem_wr      = $urandom_range(0, 1);
      mem_wr_data = $urandom;
      hs = (m_phase == P_LOAD) && load_valid;
      cycle();
      if (hs) acc++;
      guard++;
    end
    checks++;
    if (acc != n) begin
      errors++;
      $display("FAIL load_stream: accepted %0d words, required %0d", acc, n);
    end
    set_idle();
  endtask

  task automatic run_random(int n, int span);
    for (int i = 0; i < n; i++) begin
      inst_addr   = rand_addr(span);
      data_addr   = rand_addr(span);
      mem_rd      = $urandom_range(0, 1);
      mem_wr      = ($urandom_range(0, 3) == 0);
      mem_wr_data = $urandom;
      cycle();
    end
    set_idle();
  endtask

  task automatic core_op(logic [31:0] ia, logic rd, logic wr, logic [31:0] da, logic [31:0] wd);
    inst_addr   = ia;
    mem_rd      = rd;
    mem_wr      = wr;
    data_addr   = da;
    mem_wr_data = wd;
    cycle();
    set_idle();
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Reset state, then a 4-word image with last on the 4th.
    apply_reset();
    load_words(4, 1'b1, 1'b1);
    core_op(32'h8, 1'b1, 1'b0, CYC, 32'h0);
    repeat (9) core_op(32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    core_op(32'h0, 1'b1, 1'b0, CYC, 32'h0);
    core_op(32'h0, 1'b1, 1'b1, CYC, 32'h55);
    core_op(32'h0, 1'b1, 1'b0, CYC, 32'h0);

    // Store/load collision returns the pre-store word.
    core_op(32'h0, 1'b0, 1'b1, 32'h40, 32'h1234_5678);
    core_op(32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    core_op(32'h40, 1'b1, 1'b0, 32'h40, 32'h0);

    // Out-of-range fetch and load, MMIO tohost read.
    core_op(32'h1000, 1'b1, 1'b0, 32'h1000, 32'h0);
    core_op(32'h0, 1'b1, 1'b1, 32'h1003, 32'hAAAA_5555);
    core_op(32'h0, 1'b1, 1'b0, TOH, 32'h0);

    run_random(200, 32);

    // Halt; afterwards the core sees NOPs and zero reads.
    core_op(32'h0, 1'b1, 1'b1, TOH, 32'h1);
    repeat (3) core_op(32'h8, 1'b1, 1'b1, 32'h8, $urandom);

    // Reset mid-LOAD after 2 words, then a 1-word reload.
    apply_reset();
    load_words(2, 1'b0, 1'b0);
    reset = 1'b0;
    model_reset();
    cycle();
    reset = 1'b1;
    load_words(1, 1'b1, 1'b0);
    core_op(32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
    core_op(32'h4, 1'b1, 1'b0, 32'h0, 32'h0);

    // Full image with no last flag: the final index ends the stream.
    apply_reset();
    load_words(WORDS, 1'b0, 1'b0);
    run_random(400, WORDS);
    core_op(32'h0, 1'b1, 1'b1, TOH, $urandom);
    repeat (2) core_op(32'h0, 1'b1, 1'b0, CYC, 32'h0);

    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eka_mem_responder_v1.md
# eka_mem_responder_v1

Memory-side responder for the Eka single-cycle core's instruction and data ports. It serves combinational instruction fetches and data loads, and commits stores on the clock edge. It preloads the program image from a word stream while holding the core in reset, and exposes two MMIO words: a cycle counter and a tohost/halt register. It sits between the testbench/SoC top and the core, driving the core's `instruction`, `mem_rd_data` and reset.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of the instruction address.
- `MEM_WORDS`, 1024: number of 32-bit words in the unified array. Must be a power of two.
- `NOP_WORD`, 32'h0000_0013: instruction returned when the fetch is not served.

Ports:
- `clk`  in  1  processor clock.
- `reset`  in  1  asynchronous, active-low reset.
- `inst_addr`  in  ADDR_WIDTH  fetch byte address from the core.
- `instruction`  out  32  fetched word, combinational.
- `data_addr`  in  32  load/store byte address.
- `mem_wr_data`  in  32  store data.
- `mem_wr`  in  1  store request.
- `mem_rd`  in  1  load request.
- `mem_rd_data`  out  32  load data, combinational.
- `load_valid`  in  1  preload word valid.
- `load_data`  in  32  preload word.
- `load_last`  in  1  marks the final preload word.
- `load_ready`  out  1  preload word accepted this cycle when high together with `load_valid`.
- `core_reset`  out  1  active-high reset to the core.
- `halt`  out  1  program wrote tohost.
- `tohost`  out  32  value written to tohost.

## Operation
- FSM states: IDLE, LOAD, RUN, HALT.
  - IDLE → LOAD: unconditional, after one cycle.
  - LOAD → RUN: on the accepted word that has `load_last` set, or on the accepted word at index MEM_WORDS-1.
  - RUN → HALT: on a store to TOHOST_ADDR.
  - HALT is terminal until `reset`.
- Asynchronous `reset` low, from any state:
  - State returns to IDLE.
  - Load pointer, cycle counter, `tohost` and `halt` clear to 0.
  - Array contents are preserved.
- Output values by state:
  - `core_reset` = 1 in IDLE, LOAD and HALT; 0 in RUN.
  - `load_ready` = 1 only in LOAD.
  - `halt` = 1 only in HALT.
- LOAD: each handshake writes `load_data` to array[pointer], then increments the pointer. Words are not accepted in any other state.
- RUN fetch:
  - `instruction` = array[inst_addr[log2(MEM_WORDS)+1:2]] when the word index is below MEM_WORDS.
  - Otherwise `instruction` = NOP_WORD.
  - Address bits [1:0] are ignored.
- RUN data read (`mem_rd` = 1):
  - CYCLE_ADDR 32'hFFFF_FFF0 returns the cycle counter.
  - TOHOST_ADDR 32'hFFFF_FFF4 returns `tohost`.
  - An in-range array address returns the array word.
  - Any other address returns 0.
  - With `mem_rd` = 0, `mem_rd_data` = 0.
- RUN store (`mem_wr` = 1):
  - Writes the array at the posedge.
  - A store to TOHOST_ADDR latches `tohost` and enters HALT.
  - Stores to CYCLE_ADDR and to out-of-range addresses are dropped.
- Outside RUN:
  - `instruction` = NOP_WORD and `mem_rd_data` = 0.
  - Core stores are ignored.
- Cycle counter: 32-bit, increments every RUN cycle, wraps to 0 after 32'hFFFF_FFFF, and holds in HALT.
- `mem_rd` and `mem_wr` to the same address in one cycle: the read returns the pre-store value.

## Timing
- Fetch and load data: zero-cycle combinational path from address to data.
- Stores and preload writes are visible to reads in the cycle after the edge.
- Reset release: IDLE for 1 cycle, then LOAD. At the earliest, `core_reset` drops 1 cycle after the `load_last` handshake.
- Cycle counter reads 0 in the first RUN cycle.
- HALT is entered on the edge of the tohost store, so `core_reset` rises the following cycle.

## Structure
- Package `eka_mem_pkg`: state enum `mem_state_t`, CYCLE_ADDR, TOHOST_ADDR and the NOP_WORD default.
- Sub-module `eka_mem_array`:
  - Two asynchronous read ports (instruction, data).
  - One synchronous write port.
  - The FSM drives the write port through a mux: loader in LOAD, core in RUN.

## Test plan
- Reset, then stream 4 words with `load_last` on the 4th → `load_ready` is high for exactly those 4 handshakes; `core_reset` falls the next cycle; `inst_addr` 0x8 returns word 2.
- In RUN, store 0xDEADBEEF to 0x40 with a simultaneous load of 0x40 → old value that cycle, 0xDEADBEEF the next cycle.
- Fetch from 0x0000_1000 (index ≥ 1024) → `instruction` = 0x0000_0013. Load from 0x1000 → 0.
- Read CYCLE_ADDR 10 cycles into RUN → 10. Store to CYCLE_ADDR → ignored.
- Store 0x1 to TOHOST_ADDR → `halt` = 1 and `tohost` = 1 next cycle; `core_reset` = 1; counter frozen.
- Pull `reset` low mid-LOAD after 2 words, then reload 1 word with `load_last` → pointer restarted at 0; word 0 is overwritten and word 1 keeps its earlier value.
